// File: rtl/snes_pad_poller.sv
// snes_pad_poller: polls an SNES-style serial pad (latch/clock/data) once per
// frame, remaps the 16 serial bits onto the Game Boy button vector
// {Start,Select,B,A,Down,Up,Left,Right} (0 = pressed), filters impossible
// direction pairs and commits the result atomically.
// Optional build macro PAD_TURBO_EN: X/Y act as turbo A/B, alternating every
// TURBO_FRAMES committed frames.
//
// state  | meaning
// IDLE   | waiting for poll timer expiry or poll_now; latch=0, clk=1
// LATCH  | latch pulse, 2*HALF_DIV cycles
// WAIT0  | latch released, bit 0 sampled in the last cycle
// CLK_LO | pad_clk low half-period
// CLK_HI | pad_clk high half-period, bit n sampled in the last cycle
// UPDATE | commit buttons, pulse frame_valid
module snes_pad_poller #(
  parameter int HALF_DIV     = 26,
  parameter int POLL_DIV     = 69905,
  parameter int TURBO_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_now,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       frame_valid,
  output logic       busy
);

  localparam int TW = $clog2(POLL_DIV);
  localparam int HW = $clog2(2 * HALF_DIV);
  localparam logic [TW-1:0] POLL_LOAD  = TW'(POLL_DIV - 1);
  localparam logic [HW-1:0] HALF_LOAD  = HW'(HALF_DIV - 1);
  localparam logic [HW-1:0] LATCH_LOAD = HW'(2 * HALF_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    WAIT0  = 3'd2,
    CLK_LO = 3'd3,
    CLK_HI = 3'd4,
    UPDATE = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] poll_cnt;
  logic [HW-1:0] half_cnt;
  logic [3:0]    bits_left;
  logic [15:0]   shift;
  logic [1:0]    data_sync;
  logic          start_frame;
  logic [7:0]    commit_buttons;
  logic          a_bit, b_bit, up_bit, dn_bit, lf_bit, rt_bit;
  logic          unused_bits;

  assign start_frame = (state == IDLE) && (poll_now || (poll_cnt == '0));

  // Two-flop synchroniser for the asynchronous pad data line.
  always_ff @(posedge clk) begin
    if (reset) data_sync <= 2'b11;
    else       data_sync <= {data_sync[0], pad_data};
  end

  // Poll timer keeps counting through a frame; reloading at frame start keeps
  // the frame period at exactly POLL_DIV regardless of frame length.
  always_ff @(posedge clk) begin
    if (reset)                 poll_cnt <= POLL_LOAD;
    else if (start_frame)      poll_cnt <= POLL_LOAD;
    else if (poll_cnt != '0)   poll_cnt <= poll_cnt - 1'b1;
  end

`ifdef PAD_TURBO_EN
  localparam int TCW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam logic [TCW-1:0] TURBO_LOAD = TCW'(TURBO_FRAMES - 1);
  logic [TCW-1:0] turbo_cnt;
  logic           turbo_phase;

  // Turbo phase flips after every TURBO_FRAMES commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      turbo_cnt   <= TURBO_LOAD;
      turbo_phase <= 1'b0;
    end else if (state == UPDATE) begin
      if (turbo_cnt == '0) begin
        turbo_cnt   <= TURBO_LOAD;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt - 1'b1;
      end
    end
  end

  assign unused_bits = ^shift[15:10];
`else
  assign unused_bits = ^{shift[15:9], shift[1]};
`endif

  // Remap serial bits to the button vector and drop opposing direction pairs.
  always_comb begin
    a_bit  = shift[8];
    b_bit  = shift[0];
    up_bit = shift[4];
    dn_bit = shift[5];
    lf_bit = shift[6];
    rt_bit = shift[7];
`ifdef PAD_TURBO_EN
    if (turbo_phase) begin
      a_bit = shift[8] & shift[9];
      b_bit = shift[0] & shift[1];
    end
`endif
    if (!up_bit && !dn_bit) begin
      up_bit = 1'b1;
      dn_bit = 1'b1;
    end
    if (!lf_bit && !rt_bit) begin
      lf_bit = 1'b1;
      rt_bit = 1'b1;
    end
    commit_buttons = {shift[3], shift[2], b_bit, a_bit, dn_bit, up_bit, lf_bit, rt_bit};
  end

  // Frame sequencer; pad pins and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pad_latch   <= 1'b0;
      pad_clk     <= 1'b1;
      buttons     <= 8'hFF;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      half_cnt    <= '0;
      bits_left   <= '0;
      shift       <= '1;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_frame) begin
            state     <= LATCH;
            pad_latch <= 1'b1;
            half_cnt  <= LATCH_LOAD;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (half_cnt == '0) begin
            state     <= WAIT0;
            pad_latch <= 1'b0;
            half_cnt  <= HALF_LOAD;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        WAIT0: begin
          if (half_cnt == '0) begin
            shift     <= {data_sync[1], shift[15:1]};
            state     <= CLK_LO;
            pad_clk   <= 1'b0;
            half_cnt  <= HALF_LOAD;
            bits_left <= 4'd15;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        CLK_LO: begin
          if (half_cnt == '0) begin
            state    <= CLK_HI;
            pad_clk  <= 1'b1;
            half_cnt <= HALF_LOAD;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        CLK_HI: begin
          if (half_cnt == '0) begin
            shift     <= {data_sync[1], shift[15:1]};
            bits_left <= bits_left - 1'b1;
            half_cnt  <= HALF_LOAD;
            if (bits_left == 4'd1) begin
              state <= UPDATE;
            end else begin
              state   <= CLK_LO;
              pad_clk <= 1'b0;
            end
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        UPDATE: begin
          buttons     <= commit_buttons;
          frame_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state     <= IDLE;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_pad_poller.sv
// Directed bench for snes_pad_poller with a behavioural SNES pad and a
// scoreboard of expected committed button vectors. POLL_DIV is shortened so
// several frame periods fit in a short run; HALF_DIV keeps its default.
module tb_snes_pad_poller;

  localparam int HALF_DIV     = 26;
  localparam int POLL_DIV     = 2000;
  localparam int TURBO_FRAMES = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       poll_now = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, frame_valid, busy;
  logic [7:0] buttons;

  logic [15:0] pad_pattern = 16'hFFFF;
  logic [15:0] pad_sr = 16'hFFFF;

  int n_cmp = 0;
  int n_err = 0;
  int fv_seen = 0;
  int commits = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  snes_pad_poller #(
    .HALF_DIV(HALF_DIV),
    .POLL_DIV(POLL_DIV),
    .TURBO_FRAMES(TURBO_FRAMES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .poll_now(poll_now),
    .pad_data(pad_data),
    .pad_latch(pad_latch),
    .pad_clk(pad_clk),
    .buttons(buttons),
    .frame_valid(frame_valid),
    .busy(busy)
  );

  // Pad model: parallel load while latched, shift on pad_clk rising edge.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_sr = pad_pattern;
    else           pad_sr = {1'b1, pad_sr[15:1]};
  end
  assign pad_data = pad_sr[0];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected committed vector for serial pattern p as the k-th commit since reset.
  function automatic logic [7:0] model(input logic [15:0] p, input int k);
    logic a, b, up, dn, lf, rt, turbo_on, phase;
    a = p[8]; b = p[0]; up = p[4]; dn = p[5]; lf = p[6]; rt = p[7];
`ifdef PAD_TURBO_EN
    turbo_on = 1'b1;
`else
    turbo_on = 1'b0;
`endif
    phase = ((k / TURBO_FRAMES) % 2) == 1;
    if (turbo_on && phase) begin
      if (!p[9]) a = 1'b0;
      if (!p[1]) b = 1'b0;
    end
    if (!up && !dn) begin up = 1'b1; dn = 1'b1; end
    if (!lf && !rt) begin lf = 1'b1; rt = 1'b1; end
    return {p[3], p[2], b, a, dn, up, lf, rt};
  endfunction

  // Scoreboard consumer: every frame_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_seen++;
      chk1("frame_valid_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk8("buttons", buttons, exp_q.pop_front());
    end
  end

  task automatic push_frame(input logic [15:0] p);
    exp_q.push_back(model(p, commits));
    commits++;
  endtask

  task automatic start_poll(input logic [15:0] p);
    pad_pattern = p;
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    chk1("poll_start_latch", pad_latch, 1'b1);
    push_frame(p);
  endtask

  task automatic wait_fv(input string tag);
    int n;
    n = 0;
    while (!frame_valid && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk1(tag, frame_valid, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    while (!pad_latch && n < POLL_DIV + 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, w, t0, falls, rises, fv_base;
    logic prev, busy_ok, poked, latch_seen;
    logic exp_b4;

    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk8("rst_buttons", buttons, 8'hFF);
    chk1("rst_latch", pad_latch, 1'b0);
    chk1("rst_clk", pad_clk, 1'b1);
    chk1("rst_fv", frame_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;
    commits = 0;

    // First autonomous frame, pad idle
    wait_latch(n);
    chki("first_latch_cycle", n, POLL_DIV);
    push_frame(16'hFFFF);
    m = 0;
    while (pad_latch && m < 200) begin
      @(negedge clk);
      m++;
    end
    chki("latch_width", m, 2 * HALF_DIV);
    n = 0;
    while (!frame_valid && n < 1500) begin
      if (!pad_clk) begin
        w = 0;
        while (!pad_clk && w < 100) begin
          @(negedge clk);
          w++;
          n++;
        end
        chki("clk_low_width", w, HALF_DIV);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    chk1("frame1_done", frame_valid, 1'b1);
    @(negedge clk);
    chki("frame1_fv_count", fv_seen, 1);
    chk1("frame1_idle", busy, 1'b0);

    // poll_now in IDLE with A pressed, then automatic frame period
    start_poll(16'hFEFF);
    t0 = cyc;
    wait_fv("frame_a_done");
    wait_latch(n);
    chki("auto_period", cyc - t0, POLL_DIV);
    push_frame(16'hFEFF);
    wait_fv("frame_a_auto_done");

    // Filter and mapping patterns
    start_poll(16'hFF47);
    wait_fv("frame_start_updown");
    start_poll(16'hFF3A);
    wait_fv("frame_leftright");
    start_poll(16'h0000);
    wait_fv("frame_all");
    chki("fv_total", fv_seen, 6);

    // Reset during CLK_LO of bit 7 with Select held
    start_poll(16'hFFFB);
    falls = 0;
    n = 0;
    prev = pad_clk;
    while (falls < 7 && n < 1500) begin
      @(negedge clk);
      n++;
      if (prev && !pad_clk) falls++;
      prev = pad_clk;
    end
    repeat (5) @(negedge clk);
    chk1("abort_in_clk_lo", pad_clk, 1'b0);
    reset = 1'b1;
    void'(exp_q.pop_back());
    commits = 0;
    @(negedge clk);
    chk1("abort_clk", pad_clk, 1'b1);
    chk1("abort_latch", pad_latch, 1'b0);
    chk8("abort_buttons", buttons, 8'hFF);
    chk1("abort_fv", frame_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    reset = 1'b0;
    fv_base = fv_seen;
    wait_latch(n);
    chki("post_reset_latch", n, POLL_DIV);
    chki("abort_no_fv", fv_seen, fv_base);
    chk8("buttons_hold_ff", buttons, 8'hFF);
    push_frame(16'hFFFB);
    wait_fv("frame_select_done");

    // poll_now during CLK_HI is ignored
    fv_base = fv_seen;
    start_poll(16'hFF3A);
    t0 = cyc;
    busy_ok = 1'b1;
    poked = 1'b0;
    rises = 0;
    n = 0;
    prev = pad_clk;
    while (!frame_valid && n < 1500) begin
      if (!busy) busy_ok = 1'b0;
      if (poll_now) poll_now = 1'b0;
      else if (!poked && rises == 3) begin
        poll_now = 1'b1;
        poked = 1'b1;
      end
      @(negedge clk);
      n++;
      if (!prev && pad_clk) rises++;
      prev = pad_clk;
    end
    chk1("ignored_poll_done", frame_valid, 1'b1);
    chk1("ignored_poll_sent", poked, 1'b1);
    chk1("busy_continuous", busy_ok, 1'b1);
    latch_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (pad_latch) latch_seen = 1'b1;
    end
    chk1("no_queued_frame", latch_seen, 1'b0);
    chki("single_fv", fv_seen - fv_base, 1);
    wait_latch(n);
    chki("period_after_ignored_poll", cyc - t0, POLL_DIV);
    push_frame(16'hFF3A);
    wait_fv("frame_after_ignored_done");

    // Turbo: X held over six consecutive frames from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    commits = 0;
    for (int i = 0; i < 6; i++) begin
      start_poll(16'hFDFF);
      wait_fv("turbo_frame_done");
`ifdef PAD_TURBO_EN
      exp_b4 = ((i / 2) % 2) == 0;
`else
      exp_b4 = 1'b1;
`endif
      chk1("turbo_a_bit", buttons[4], exp_b4);
    end
    chki("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
